// File: rtl/reduction_flag_tracker.sv
// Sequential checker stage behind the 8-bit reduction unit. It registers each valid flag
// sample, flags rising edges, and keeps one saturating event counter per flag. A small
// request/response FSM returns a single counter value two cycles after each request.
module reduction_flag_tracker #(
    parameter int unsigned NFLAGS = 5,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [NFLAGS-1:0] in_flags,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [2:0]        rd_sel,
    output logic [NFLAGS-1:0] flags_q,
    output logic              any_edge,
    output logic              busy,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data
);

    localparam int unsigned SEL_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [NFLAGS-1:0]            rise;
    logic [NFLAGS-1:0][CNT_W-1:0] cnt;
    logic [NFLAGS-1:0][CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0]             sel_cnt;
    logic [SEL_W-1:0]             sel;
    state_t                       state;
    state_t                       state_nxt;
    logic                         cap_sel;
    logic                         load_data;

    // Rising flags relative to the last accepted sample (all-zero after reset or clear)
    assign rise = in_flags & ~flags_q;

    // Flag sample register and one-cycle rising-edge pulse; clear discards the sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q  <= '0;
            any_edge <= 1'b0;
        end else if (clear) begin
            flags_q  <= '0;
            any_edge <= 1'b0;
        end else if (in_valid) begin
            flags_q  <= in_flags;
            any_edge <= |rise;
        end else begin
            any_edge <= 1'b0;
        end
    end

    // Per-flag counter update: increment on a rising flag, stick at the maximum value
    always_comb begin
        cnt_nxt = cnt;
        for (int i = 0; i < int'(NFLAGS); i++) begin
            if (clear) begin
                cnt_nxt[i] = '0;
            end else if (in_valid && rise[i] && (cnt[i] != CNT_MAX)) begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Event counter bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Counter selected by the captured index; indices past the last flag read as zero
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < int'(NFLAGS); i++) begin
            if (sel == SEL_W'(i)) begin
                sel_cnt = cnt[i];
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM next state and capture/load strobes; requests outside IDLE are dropped
    always_comb begin
        state_nxt = state;
        cap_sel   = 1'b0;
        load_data = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    cap_sel   = 1'b1;
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                load_data = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered read-side outputs, derived from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (cap_sel) begin
                sel <= rd_sel;
            end
            if (load_data) begin
                rd_data <= sel_cnt;
            end
            busy     <= (state_nxt != IDLE);
            rd_valid <= (state_nxt == RESP);
        end
    end

endmodule

// File: tb/tb_reduction_flag_tracker.sv
// Self-checking bench for reduction_flag_tracker: directed vector table, hand-written
// read/clear/reset sequences, and randomized traffic against a behavioural model.
module tb_reduction_flag_tracker;

    localparam int unsigned NFLAGS = 5;
    localparam int unsigned CNT_W  = 8;
    localparam int          CMAX   = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [NFLAGS-1:0] in_flags;
    logic              clear;
    logic              rd_req;
    logic [2:0]        rd_sel;
    logic [NFLAGS-1:0] flags_q;
    logic              any_edge;
    logic              busy;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: last accepted sample, edge pulse and event counts
    logic [NFLAGS-1:0] m_flags;
    logic              m_edge;
    int                m_cnt[NFLAGS];

    typedef struct {
        logic              v;
        logic [NFLAGS-1:0] f;
        logic              c;
        logic [NFLAGS-1:0] exp_f;
        logic              exp_e;
    } vec_t;

    vec_t tbl[9];

    reduction_flag_tracker #(.NFLAGS(NFLAGS), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_flags (in_flags),
        .clear    (clear),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .flags_q  (flags_q),
        .any_edge (any_edge),
        .busy     (busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_edge  = 1'b0;
        for (int i = 0; i < int'(NFLAGS); i++) m_cnt[i] = 0;
    endtask

    function automatic int model_read(input int s);
        return (s < int'(NFLAGS)) ? m_cnt[s] : 0;
    endfunction

    // Drive one cycle of sample inputs at the negedge, clock it, advance model, check
    task automatic step_model(input logic v, input logic [NFLAGS-1:0] f, input logic c);
        in_valid = v;
        in_flags = f;
        clear    = c;
        @(posedge clk);
        @(negedge clk);
        if (c) begin
            model_reset();
        end else if (v) begin
            m_edge = 1'b0;
            for (int i = 0; i < int'(NFLAGS); i++) begin
                if (f[i] && !m_flags[i]) begin
                    m_edge = 1'b1;
                    if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_flags = f;
        end else begin
            m_edge = 1'b0;
        end
        chk("flags_q", 32'(flags_q), 32'(m_flags));
        chk("any_edge", 32'(any_edge), 32'(m_edge));
    endtask

    // Full read transaction; optionally inject a sample during the CAPT cycle
    task automatic do_read(input int s, input logic inj_v, input logic [NFLAGS-1:0] inj_f,
                           output int got);
        int exp;
        rd_req = 1'b1;
        rd_sel = 3'(s);
        step_model(1'b0, '0, 1'b0);
        chk("busy_capt", 32'(busy), 32'd1);
        chk("rd_valid_capt", 32'(rd_valid), 32'd0);
        exp = model_read(s);
        rd_sel = 3'(s ^ 1);
        step_model(inj_v, inj_f, 1'b0);
        rd_req = 1'b0;
        chk("busy_resp", 32'(busy), 32'd1);
        chk("rd_valid_resp", 32'(rd_valid), 32'd1);
        chk("rd_data", 32'(rd_data), 32'(exp));
        got = int'(rd_data);
        step_model(1'b0, '0, 1'b0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);
        chk("rd_data_hold", 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int got;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_flags = '0;
        clear    = 1'b0;
        rd_req   = 1'b0;
        rd_sel   = '0;
        model_reset();

        tbl[0] = '{1'b1, 5'b10101, 1'b0, 5'b10101, 1'b1};
        tbl[1] = '{1'b1, 5'b10101, 1'b0, 5'b10101, 1'b0};
        tbl[2] = '{1'b1, 5'b10101, 1'b0, 5'b10101, 1'b0};
        tbl[3] = '{1'b1, 5'b10101, 1'b0, 5'b10101, 1'b0};
        tbl[4] = '{1'b1, 5'b01010, 1'b0, 5'b01010, 1'b1};
        tbl[5] = '{1'b1, 5'b11111, 1'b0, 5'b11111, 1'b1};
        tbl[6] = '{1'b0, 5'b00000, 1'b0, 5'b11111, 1'b0};
        tbl[7] = '{1'b1, 5'b11111, 1'b1, 5'b00000, 1'b0};
        tbl[8] = '{1'b1, 5'b00100, 1'b0, 5'b00100, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_flags_q", 32'(flags_q), 32'd0);
        chk("rst_any_edge", 32'(any_edge), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

        // Directed vectors, first part (no clear yet)
        for (int i = 0; i < 7; i++) begin
            step_model(tbl[i].v, tbl[i].f, tbl[i].c);
            chk("tbl_flags_q", 32'(flags_q), 32'(tbl[i].exp_f));
            chk("tbl_any_edge", 32'(any_edge), 32'(tbl[i].exp_e));
        end
        do_read(0, 1'b0, '0, got); chk("cnt0_after_seq", 32'(got), 32'd2);
        do_read(1, 1'b0, '0, got); chk("cnt1_after_seq", 32'(got), 32'd1);
        do_read(2, 1'b0, '0, got); chk("cnt2_after_seq", 32'(got), 32'd2);
        do_read(3, 1'b0, '0, got); chk("cnt3_after_seq", 32'(got), 32'd1);
        do_read(4, 1'b0, '0, got); chk("cnt4_after_seq", 32'(got), 32'd2);
        do_read(7, 1'b0, '0, got); chk("sel7_reads_zero", 32'(got), 32'd0);
        do_read(5, 1'b0, '0, got); chk("sel5_reads_zero", 32'(got), 32'd0);

        // Clear beats same-cycle sample, then first sample after clear counts
        for (int i = 7; i < 9; i++) begin
            step_model(tbl[i].v, tbl[i].f, tbl[i].c);
            chk("tbl_flags_q", 32'(flags_q), 32'(tbl[i].exp_f));
            chk("tbl_any_edge", 32'(any_edge), 32'(tbl[i].exp_e));
        end
        do_read(0, 1'b0, '0, got); chk("cnt0_after_clear", 32'(got), 32'd0);
        do_read(2, 1'b0, '0, got); chk("cnt2_after_clear", 32'(got), 32'd1);

        // Read whose CAPT edge coincides with an increment returns the old value
        step_model(1'b1, 5'b00000, 1'b0);
        do_read(2, 1'b1, 5'b00100, got); chk("capt_pre_increment", 32'(got), 32'd1);
        do_read(2, 1'b0, '0, got); chk("post_increment", 32'(got), 32'd2);

        // Saturation: 300 rising edges on flag0
        step_model(1'b1, 5'b00000, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step_model(1'b1, 5'b00001, 1'b0);
            step_model(1'b1, 5'b00000, 1'b0);
        end
        do_read(0, 1'b0, '0, got); chk("cnt0_saturated", 32'(got), 32'd255);

        // Reset asserted while the FSM sits in CAPT
        rd_req = 1'b1;
        rd_sel = 3'd0;
        step_model(1'b1, 5'b00010, 1'b0);
        rd_req = 1'b0;
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        chk("midrst_flags_q", 32'(flags_q), 32'd0);
        chk("midrst_any_edge", 32'(any_edge), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_model(1'b0, '0, 1'b0);
            chk("midrst_no_resp", 32'(rd_valid), 32'd0);
        end
        do_read(0, 1'b0, '0, got); chk("read_after_midrst", 32'(got), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic c;
            logic [NFLAGS-1:0] f;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            f = NFLAGS'($urandom);
            step_model(v, f, c);
            if ((i % 20) == 19) do_read(int'($urandom_range(0, 7)), 1'b0, '0, got);
        end
        for (int s = 0; s < 8; s++) do_read(s, 1'b0, '0, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
